// File: rtl/shift_right.sv
// shift_right
//
// Purpose:
//   Registered right-shift unit for the 8-bit ALU datapath. A combinational
//   barrel shifter feeds a single output register stage, so every accepted
//   request appears on the outputs exactly one clock later.
//
// Parameters:
//   WIDTH     operand/result width (power of two, >= 2)
//   SHW       shift-amount width, derived as log2(WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request strobe, operands sampled on a clk edge when high
//   op         operand to shift
//   shamt      shift distance 0..WIDTH-1
//   mode       00 logical, 01 arithmetic, 10 rotate-right, 11 as logical
//   result     shifted operand (registered)
//   carry      last bit shifted out (registered)
//   zero       high when result is zero (registered)
//   out_valid  one-cycle pulse per accepted request

module shift_right #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           op,
  input  logic [$clog2(WIDTH)-1:0]   shamt,
  input  logic [1:0]                 mode,
  output logic [WIDTH-1:0]           result,
  output logic                       carry,
  output logic                       zero,
  output logic                       out_valid
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    MODE_LOGICAL  = 2'b00,
    MODE_ARITH    = 2'b01,
    MODE_ROTATE   = 2'b10,
    MODE_RESERVED = 2'b11
  } shift_mode_e;

  logic [WIDTH-1:0]   logical_res;
  logic [WIDTH-1:0]   arith_res;
  logic [2*WIDTH-1:0] rotate_dbl;
  logic [WIDTH-1:0]   shifted;
  logic               carry_out;

  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               out_valid_q, out_valid_d;

  assign logical_res = op >> shamt;
  assign arith_res   = WIDTH'($signed(op) >>> shamt);
  // Rotating a doubled copy lets the low bits that fall off re-enter at the top.
  assign rotate_dbl  = {op, op} >> shamt;

  always_comb begin
    shifted = logical_res;
    case (shift_mode_e'(mode))
      MODE_ARITH:    shifted = arith_res;
      MODE_ROTATE:   shifted = rotate_dbl[WIDTH-1:0];
      MODE_LOGICAL,
      MODE_RESERVED: shifted = logical_res;
      default:       shifted = logical_res;
    endcase
  end

  // The last bit shifted out is op[shamt-1]; the index is only used when
  // shamt is non-zero, so the wrap of shamt-1 at zero never matters.
  always_comb begin
    carry_out = 1'b0;
    if (shamt != '0) begin
      carry_out = op[shamt - SHW'(1)];
    end
  end

  // Data fields hold when no request is sampled; only the strobe drops.
  always_comb begin
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      result_d = shifted;
      carry_d  = carry_out;
      zero_d   = (shifted == '0);
    end
  end

  // Reset clears the pipeline register, which also discards any request
  // captured just before reset asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shift_right.sv
// tb_shift_right
//
// Purpose:
//   Directed self-checking bench for shift_right (WIDTH=8). Each scenario
//   task drives its own requests and compares the registered outputs against
//   hand-computed values, sampling 1 time unit after the rising edge.

module tb_shift_right;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] op;
  logic [2:0] shamt;
  logic [1:0] mode;
  logic [7:0] result;
  logic       carry;
  logic       zero;
  logic       out_valid;

  int checkCount;
  int errorCount;

  shift_right #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .op        (op),
    .shamt     (shamt),
    .mode      (mode),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .out_valid (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one request on the falling edge and returns just after the
  // rising edge that captures it, leaving in_valid high for back-to-back use.
  task automatic issueRequest(input logic [7:0] opV, input logic [2:0] shV,
                              input logic [1:0] modeV);
    @(negedge clk);
    op       = opV;
    shamt    = shV;
    mode     = modeV;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if (result !== 8'h00) begin
      errorCount++;
      $display("[TB] FAIL reset_result got %b want %b", result, 8'h00);
    end
    checkCount++;
    if (carry !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_carry got %b want 0", carry);
    end
    checkCount++;
    if (zero !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL reset_zero got %b want 1", zero);
    end
    checkCount++;
    if (out_valid !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkCount++;
    if ({result, carry, zero, out_valid} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
      errorCount++;
      $display("[TB] FAIL reset_hold got r=%b c=%b z=%b v=%b want r=00000000 c=0 z=1 v=0",
               result, carry, zero, out_valid);
    end
  endtask

  task automatic test_shift_by_one();
    issueRequest(8'b0000_1111, 3'd1, 2'b00);
    checkCount++;
    if ({result, carry, zero, out_valid} !== {8'b0000_0111, 1'b1, 1'b0, 1'b1}) begin
      errorCount++;
      $display("[TB] FAIL shr1_0f got r=%b c=%b z=%b v=%b want r=00000111 c=1 z=0 v=1",
               result, carry, zero, out_valid);
    end
    issueRequest(8'b0000_0001, 3'd1, 2'b00);
    checkCount++;
    if ({result, carry, zero, out_valid} !== {8'b0000_0000, 1'b1, 1'b1, 1'b1}) begin
      errorCount++;
      $display("[TB] FAIL shr1_01 got r=%b c=%b z=%b v=%b want r=00000000 c=1 z=1 v=1",
               result, carry, zero, out_valid);
    end
  endtask

  task automatic test_arith_vs_logical();
    issueRequest(8'b1000_0000, 3'd3, 2'b01);
    checkCount++;
    if ({result, carry, zero} !== {8'b1111_0000, 1'b0, 1'b0}) begin
      errorCount++;
      $display("[TB] FAIL arith3 got r=%b c=%b z=%b want r=11110000 c=0 z=0",
               result, carry, zero);
    end
    issueRequest(8'b1000_0000, 3'd3, 2'b00);
    checkCount++;
    if ({result, carry, zero} !== {8'b0001_0000, 1'b0, 1'b0}) begin
      errorCount++;
      $display("[TB] FAIL logical3 got r=%b c=%b z=%b want r=00010000 c=0 z=0",
               result, carry, zero);
    end
    issueRequest(8'b1000_0000, 3'd3, 2'b11);
    checkCount++;
    if ({result, carry, zero, out_valid} !== {8'b0001_0000, 1'b0, 1'b0, 1'b1}) begin
      errorCount++;
      $display("[TB] FAIL reserved3 got r=%b c=%b z=%b v=%b want r=00010000 c=0 z=0 v=1",
               result, carry, zero, out_valid);
    end
    // Sign bit clear with carry out set, arithmetic must zero-fill here.
    issueRequest(8'b0110_0101, 3'd3, 2'b01);
    checkCount++;
    if ({result, carry} !== {8'b0000_1100, 1'b1}) begin
      errorCount++;
      $display("[TB] FAIL arith3_pos got r=%b c=%b want r=00001100 c=1", result, carry);
    end
    issueRequest(8'b1100_0110, 3'd2, 2'b11);
    checkCount++;
    if ({result, carry, zero} !== {8'b0011_0001, 1'b1, 1'b0}) begin
      errorCount++;
      $display("[TB] FAIL reserved2 got r=%b c=%b z=%b want r=00110001 c=1 z=0",
               result, carry, zero);
    end
  endtask

  task automatic test_rotate();
    issueRequest(8'b0000_0001, 3'd1, 2'b10);
    checkCount++;
    if ({result, carry, zero} !== {8'b1000_0000, 1'b1, 1'b0}) begin
      errorCount++;
      $display("[TB] FAIL rot1 got r=%b c=%b z=%b want r=10000000 c=1 z=0",
               result, carry, zero);
    end
    issueRequest(8'b1011_0001, 3'd7, 2'b10);
    checkCount++;
    if ({result, carry, zero} !== {8'b0110_0011, 1'b0, 1'b0}) begin
      errorCount++;
      $display("[TB] FAIL rot7 got r=%b c=%b z=%b want r=01100011 c=0 z=0",
               result, carry, zero);
    end
    for (int m = 0; m < 4; m++) begin
      issueRequest(8'b1011_0001, 3'd0, 2'(m));
      checkCount++;
      if ({result, carry, zero, out_valid} !== {8'b1011_0001, 1'b0, 1'b0, 1'b1}) begin
        errorCount++;
        $display("[TB] FAIL shamt0_mode%0d got r=%b c=%b z=%b v=%b want r=10110001 c=0 z=0 v=1",
                 m, result, carry, zero, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    issueRequest(8'h0F, 3'd4, 2'b00);
    checkCount++;
    if ({result, carry, zero, out_valid} !== {8'h00, 1'b1, 1'b1, 1'b1}) begin
      errorCount++;
      $display("[TB] FAIL b2b_0 got r=%h c=%b z=%b v=%b want r=00 c=1 z=1 v=1",
               result, carry, zero, out_valid);
    end
    issueRequest(8'hF0, 3'd4, 2'b00);
    checkCount++;
    if ({result, carry, zero, out_valid} !== {8'h0F, 1'b0, 1'b0, 1'b1}) begin
      errorCount++;
      $display("[TB] FAIL b2b_1 got r=%h c=%b z=%b v=%b want r=0f c=0 z=0 v=1",
               result, carry, zero, out_valid);
    end
    issueRequest(8'hFF, 3'd4, 2'b00);
    checkCount++;
    if ({result, carry, zero, out_valid} !== {8'h0F, 1'b1, 1'b0, 1'b1}) begin
      errorCount++;
      $display("[TB] FAIL b2b_2 got r=%h c=%b z=%b v=%b want r=0f c=1 z=0 v=1",
               result, carry, zero, out_valid);
    end
    // Change the operand while idle; the held outputs must not follow it.
    @(negedge clk);
    in_valid = 1'b0;
    op       = 8'h00;
    @(posedge clk);
    #1;
    checkCount++;
    if ({result, carry, zero, out_valid} !== {8'h0F, 1'b1, 1'b0, 1'b0}) begin
      errorCount++;
      $display("[TB] FAIL hold got r=%h c=%b z=%b v=%b want r=0f c=1 z=0 v=0",
               result, carry, zero, out_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    op       = 8'hAA;
    shamt    = 3'd1;
    mode     = 2'b00;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if ({result, zero, out_valid} !== {8'h00, 1'b1, 1'b0}) begin
      errorCount++;
      $display("[TB] FAIL midrst_assert got r=%h z=%b v=%b want r=00 z=1 v=0",
               result, zero, out_valid);
    end
    @(posedge clk);
    #1;
    checkCount++;
    if ({result, out_valid} !== {8'h00, 1'b0}) begin
      errorCount++;
      $display("[TB] FAIL midrst_edge got r=%h v=%b want r=00 v=0", result, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checkCount++;
      if ({result, carry, zero, out_valid} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
        errorCount++;
        $display("[TB] FAIL midrst_release%0d got r=%h c=%b z=%b v=%b want r=00 c=0 z=1 v=0",
                 i, result, carry, zero, out_valid);
      end
    end
    idleCycle();
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n      = 1'b1;
    in_valid   = 1'b0;
    op         = 8'h00;
    shamt      = 3'd0;
    mode       = 2'b00;
    test_reset();
    test_shift_by_one();
    test_arith_vs_logical();
    test_rotate();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
